// File: rtl/lib_intr.sv
// Shared definitions for the interrupt controller: config register map, FSM states,
// and the packed configuration record.
package lib_intr;

    localparam int unsigned CFG_ADDR_ENABLE   = 0;
    localparam int unsigned CFG_ADDR_MODE     = 1;
    localparam int unsigned CFG_ADDR_PENDING  = 2;
    localparam int unsigned CFG_ADDR_VEC_BASE = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } INTR_STATE;

    typedef struct packed {
        logic [31:0] enable;
        logic [31:0] mode;
        logic [31:0] vec_base;
    } INTR_CFG;

    // Mask covering the low n bits of a 32-bit register (n in 1..32).
    function automatic logic [31:0] src_mask(input int n);
        return 32'((64'd1 << n) - 64'd1);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of vec and whether any bit is set.
module intr_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    logic [N_SRC-1:0] onehot;

    // A bit wins only if no lower-indexed bit is set.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_onehot
            localparam logic [N_SRC-1:0] LOWER = N_SRC'((64'd1 << gi) - 64'd1);
            assign onehot[gi] = vec[gi] & ~(|(vec & LOWER));
        end
    endgenerate

    assign valid = |vec;

    always_comb begin
        id = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (onehot[i]) begin
                id = id | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: pending latch, mask, priority pick, request/ack/EOI FSM.
// Define INTR_CTRL_NEST_EN to enable the in-service stack with priority preemption.
module intr_ctrl
    import lib_intr::*;
#(
    parameter int N_SRC  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src,
    input  logic              intr_en,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              irq_req,
    output logic [31:0]       irq_vec,
    input  logic              irq_ack,
    input  logic              irq_eoi
);

    localparam int          ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [31:0] SRC_MASK = src_mask(N_SRC);

    INTR_CFG          cfg_q, cfg_d;
    INTR_STATE        state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [31:0]      vec_q, vec_d;

    logic [31:0]      addr_ext;
    logic             wr_enable, wr_mode, wr_pend, wr_base;
    logic [N_SRC-1:0] enable_v, mode_v, elig, clr, set_edge;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;
    logic             ack_fire, eoi_fire, preempt, last_pop, load;

    assign addr_ext  = 32'(cfg_addr);
    assign wr_enable = cfg_we && (addr_ext == CFG_ADDR_ENABLE);
    assign wr_mode   = cfg_we && (addr_ext == CFG_ADDR_MODE);
    assign wr_pend   = cfg_we && (addr_ext == CFG_ADDR_PENDING);
    assign wr_base   = cfg_we && (addr_ext == CFG_ADDR_VEC_BASE);

    assign enable_v = cfg_q.enable[N_SRC-1:0];
    assign mode_v   = cfg_q.mode[N_SRC-1:0];
    assign elig     = pend_q & enable_v;
    assign ack_fire = (state_q == REQ) && irq_ack;
    assign eoi_fire = (state_q == SERVICE) && irq_eoi;

    intr_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .vec   (elig),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        cfg_d = cfg_q;
        if (wr_enable) cfg_d.enable   = cfg_wdata & SRC_MASK;
        if (wr_mode)   cfg_d.mode     = cfg_wdata & SRC_MASK;
        if (wr_base)   cfg_d.vec_base = cfg_wdata;
    end

    // Edge bits: set beats clear. Level bits simply track the line.
    always_comb begin
        src_d    = src;
        set_edge = src & ~src_q;
        clr      = '0;
        if (wr_pend)  clr = cfg_wdata[N_SRC-1:0];
        if (ack_fire) clr[cur_id_q] = 1'b1;
        pend_d = (mode_v & (set_edge | (pend_q & ~clr))) | (~mode_v & src);
    end

`ifdef INTR_CTRL_NEST_EN
    localparam int SP_W = $clog2(N_SRC + 1);

    logic [ID_W-1:0] stack_q [N_SRC];
    logic [ID_W-1:0] stack_d [N_SRC];
    logic [SP_W-1:0] sp_q, sp_d;
    logic [ID_W-1:0] top_id;

    assign top_id   = (sp_q == '0) ? '0 : stack_q[ID_W'(sp_q - SP_W'(1))];
    assign last_pop = (sp_q == SP_W'(1));
    // EOI takes precedence over a same-cycle preemption.
    assign preempt  = (state_q == SERVICE) && !irq_eoi && win_valid && intr_en
                      && (win_id < top_id);

    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        if (ack_fire) begin
            stack_d[ID_W'(sp_q)] = cur_id_q;
            sp_d = sp_q + SP_W'(1);
        end else if (eoi_fire) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
            for (int i = 0; i < N_SRC; i++) stack_q[i] <= '0;
        end else begin
            sp_q    <= sp_d;
            stack_q <= stack_d;
        end
    end
`else
    assign preempt  = 1'b0;
    assign last_pop = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid && intr_en) state_d = REQ;
            REQ:     if (irq_ack) state_d = SERVICE;
            SERVICE: begin
                if (irq_eoi)      state_d = last_pop ? IDLE : SERVICE;
                else if (preempt) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Id and vector are captured on entry to REQ so the request stays stable until ack.
    assign load = (state_d == REQ) && (state_q != REQ);

    always_comb begin
        cur_id_d = cur_id_q;
        vec_d    = vec_q;
        if (load) begin
            cur_id_d = win_id;
            vec_d    = cfg_q.vec_base + (32'(win_id) << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q    <= '0;
            state_q  <= IDLE;
            pend_q   <= '0;
            src_q    <= '0;
            cur_id_q <= '0;
            vec_q    <= '0;
        end else begin
            cfg_q    <= cfg_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            src_q    <= src_d;
            cur_id_q <= cur_id_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        irq_req = (state_q == REQ);
        irq_vec = irq_req ? vec_q : 32'd0;
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (addr_ext)
            CFG_ADDR_ENABLE:   cfg_rdata = cfg_q.enable;
            CFG_ADDR_MODE:     cfg_rdata = cfg_q.mode;
            CFG_ADDR_PENDING:  cfg_rdata = 32'(pend_q);
            CFG_ADDR_VEC_BASE: cfg_rdata = cfg_q.vec_base;
            default:           cfg_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Table-driven bench for intr_ctrl: each row drives one cycle of inputs, then checks the
// request, vector and (optionally) a config readback just after the clock edge.
module tb_intr_ctrl;

`ifdef INTR_CTRL_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src;
    logic        intr_en;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_req;
    logic [31:0] irq_vec;
    logic        irq_ack;
    logic        irq_eoi;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.N_SRC(8), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .intr_en   (intr_en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi)
    );

    typedef struct {
        logic [7:0]  src;
        logic        en;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        ack;
        logic        eoi;
        logic        exp_req;
        logic [31:0] exp_vec;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] s, input logic en, input logic we,
                                input logic [1:0] a, input logic [31:0] wd,
                                input logic ack, input logic eoi, input logic req,
                                input logic [31:0] vec, input logic chk, input logic [31:0] rd);
        vec_t v;
        v.src = s; v.en = en; v.we = we; v.addr = a; v.wd = wd; v.ack = ack; v.eoi = eoi;
        v.exp_req = req; v.exp_vec = vec; v.chk_rd = chk; v.exp_rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        src = v.src; intr_en = v.en; cfg_we = v.we; cfg_addr = v.addr; cfg_wdata = v.wd;
        irq_ack = v.ack; irq_eoi = v.eoi;
        @(posedge clk);
        #1;
        $display("row %0d: src=%02h en=%0b we=%0b a=%0d ack=%0b eoi=%0b -> req=%0b vec=%08h rd=%08h",
                 idx, v.src, v.en, v.we, v.addr, v.ack, v.eoi, irq_req, irq_vec, cfg_rdata);
        check($sformatf("row%0d.req", idx), 32'(irq_req), 32'(v.exp_req));
        check($sformatf("row%0d.vec", idx), irq_vec, v.exp_vec);
        if (v.chk_rd) check($sformatf("row%0d.rdata", idx), cfg_rdata, v.exp_rd);
    endtask

    initial begin
        reset = 1'b1; src = '0; intr_en = 1'b1; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.req", 32'(irq_req), 32'd0);
        check("reset.vec", irq_vec, 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            check($sformatf("reset.rd%0d", a), cfg_rdata, 32'd0);
        end
        reset = 1'b0;

        // Single edge source 0, base 0x100
        tbl.push_back(mk(8'h00, 1, 1, 0, 32'h01,  0, 0, 0, 32'h0,   1, 32'h01));
        tbl.push_back(mk(8'h00, 1, 1, 1, 32'h01,  0, 0, 0, 32'h0,   1, 32'h01));
        tbl.push_back(mk(8'h00, 1, 1, 3, 32'h100, 0, 0, 0, 32'h0,   1, 32'h100));
        tbl.push_back(mk(8'h01, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h01));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   0, 0, 1, 32'h100, 1, 32'h01));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   0, 0, 1, 32'h100, 1, 32'h01));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   1, 0, 0, 32'h0,   1, 32'h00));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        // Sources 3 and 5 together: 3 first, then 5 after EOI; source 2 is level
        tbl.push_back(mk(8'h00, 1, 1, 0, 32'h2D,  0, 0, 0, 32'h0,   1, 32'h2D));
        tbl.push_back(mk(8'h00, 1, 1, 1, 32'h29,  0, 0, 0, 32'h0,   1, 32'h29));
        tbl.push_back(mk(8'h28, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h28));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   0, 0, 1, 32'h10C, 1, 32'h28));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   1, 0, 0, 32'h0,   1, 32'h20));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 1, 32'h114, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   1, 0, 0, 32'h0,   1, 32'h00));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        // Level source 2 held through EOI re-requests; dropping it stops requests
        tbl.push_back(mk(8'h04, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h04));
        tbl.push_back(mk(8'h04, 1, 0, 0, 32'h0,   0, 0, 1, 32'h108, 0, 32'h0));
        tbl.push_back(mk(8'h04, 1, 0, 2, 32'h0,   1, 0, 0, 32'h0,   1, 32'h04));
        tbl.push_back(mk(8'h04, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h04, 1, 0, 0, 32'h0,   0, 0, 1, 32'h108, 0, 32'h0));
        tbl.push_back(mk(8'h04, 1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   0, 1, 0, 32'h0,   1, 32'h00));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        // Global enable gating, then ack+eoi in the same cycle (eoi must be ignored)
        tbl.push_back(mk(8'h01, 0, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h01));
        tbl.push_back(mk(8'h00, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   1, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h01, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        // W1C colliding with a new edge on source 3: set wins; a plain W1C then clears
        tbl.push_back(mk(8'h08, 0, 1, 2, 32'h08,  0, 0, 0, 32'h0,   1, 32'h08));
        tbl.push_back(mk(8'h00, 0, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h08));
        tbl.push_back(mk(8'h00, 0, 1, 2, 32'h08,  0, 0, 0, 32'h0,   1, 32'h00));
        // Higher-priority source 1 arriving while source 4 is in service
        tbl.push_back(mk(8'h00, 1, 1, 0, 32'h13,  0, 0, 0, 32'h0,   1, 32'h13));
        tbl.push_back(mk(8'h00, 1, 1, 1, 32'h13,  0, 0, 0, 32'h0,   1, 32'h13));
        tbl.push_back(mk(8'h10, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h10));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 1, 32'h110, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h02, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h02));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, NEST, NEST ? 32'h104 : 32'h0, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   1, 0, 0, 32'h0,   1, NEST ? 32'h00 : 32'h02));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, !NEST, NEST ? 32'h0 : 32'h104, 0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   1, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 2, 32'h0,   0, 0, 0, 32'h0,   1, 32'h00));
        // Lead-in to a reset asserted while a request is outstanding
        tbl.push_back(mk(8'h01, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 32'h0,   0, 0, 1, 32'h100, 1, 32'h13));

        foreach (tbl[i]) apply(tbl[i], i);

        reset = 1'b1; cfg_addr = 2'd0;
        @(posedge clk);
        #1;
        $display("reset mid-REQ: req=%0b vec=%08h rd0=%08h", irq_req, irq_vec, cfg_rdata);
        check("midreset.req", 32'(irq_req), 32'd0);
        check("midreset.vec", irq_vec, 32'd0);
        check("midreset.enable", cfg_rdata, 32'd0);
        cfg_addr = 2'd3;
        #1;
        check("midreset.base", cfg_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postreset.req", 32'(irq_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
